ram_responder: RTL and testbench

Word-addressed main-memory responder: the RAM end of the cache-to-RAM interface (`ram_read`/`ram_write`/`ram_atomic`/`ram_wait`). It sits behind a data cache and serves single-word reads, writes and atomic swaps against an internal storage array. A programmable number of wait states models memory latency. Completion is signalled by a one-cycle `ram_ack` pulse.

---
 rtl/ram_responder_pkg.sv | 32 +++
 rtl/ram_responder_array.sv | 30 +++
 rtl/ram_responder.sv | 161 ++++++++++++++++
 tb/tb_ram_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// Shared widths, FSM/op encodings and request decode for the RAM responder.
package ram_responder_pkg;

  localparam int DATA_W      = 32;
  localparam int DATA_ADDR_W = 32;

  typedef enum logic [1:0] {
    RR_IDLE = 2'd0,
    RR_BUSY = 2'd1,
    RR_RESP = 2'd2
  } rr_state_e;

  typedef enum logic [1:0] {
    RR_OP_RD  = 2'd0,
    RR_OP_WR  = 2'd1,
    RR_OP_SWP = 2'd2
  } rr_op_e;

  // Atomic only qualifies writes; a read with atomic set stays a plain read.
  function automatic rr_op_e rr_decode_op(input logic wr, input logic atomic);
    rr_op_e op;
    if (wr && atomic) begin
      op = RR_OP_SWP;
    end else if (wr) begin
      op = RR_OP_WR;
    end else begin
      op = RR_OP_RD;
    end
    return op;
  endfunction

endpackage

// File: rtl/ram_responder_array.sv
// Single-port storage with synchronous read-before-write; contents have no reset.
module ram_responder_array #(
  parameter int WORDS = 4096,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [WORDS];

  // Read port captures the old word even when the same edge writes a new one.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (re_i) begin
        rdata_o <= mem_q[addr_i];
      end
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/ram_responder.sv
// RAM end of the cache-to-RAM link: wait-state FSM, op latch, range/protocol error and storage.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int    MEM_WORDS = 4096,
  parameter int    IDX_W     = 12,
  parameter int    LATENCY   = 3,
  parameter string INIT_FILE = ""
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0]      ram_data_w,
  input  logic                   ram_read,
  input  logic                   ram_write,
  input  logic                   ram_atomic,
  output logic                   ram_wait,
  output logic                   ram_ack,
  output logic [DATA_W-1:0]      ram_data_r,
  output logic                   ram_err
);

  localparam logic [7:0] LAT_M1  = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;
  localparam logic       NO_WAIT = (LATENCY == 0);

  rr_state_e              state_q, state_d;
  rr_op_e                 op_q, op_d, cur_op_s;
  logic [7:0]             cnt_q, cnt_d;
  logic [DATA_ADDR_W-1:0] addr_q, addr_d, cur_addr_s;
  logic [DATA_W-1:0]      wdata_q, wdata_d, cur_wdata_s, arr_rdata_s;
  logic                   both_q, both_d, cur_both_s;
  logic                   err_q, err_d, rsel_q, rsel_d;
  logic                   wait_q, wait_d, ack_q, ack_d;
  logic                   req_s, idle_s, access_s, oor_s;

  // In IDLE the live request is used directly so a zero-wait access commits on the accepting edge.
  always_comb begin
    req_s  = ram_read | ram_write;
    idle_s = (state_q == RR_IDLE);
    if (idle_s) begin
      cur_op_s    = rr_decode_op(ram_write, ram_atomic);
      cur_addr_s  = ram_addr;
      cur_wdata_s = ram_data_w;
      cur_both_s  = ram_read & ram_write & ~ram_atomic;
    end else begin
      cur_op_s    = op_q;
      cur_addr_s  = addr_q;
      cur_wdata_s = wdata_q;
      cur_both_s  = both_q;
    end
    access_s = (idle_s & req_s & NO_WAIT) | ((state_q == RR_BUSY) & (cnt_q == 8'd0));
    oor_s    = |cur_addr_s[DATA_ADDR_W-1:IDX_W];
  end

  // Next-state and wait-state counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RR_IDLE: begin
        if (req_s && NO_WAIT) begin
          state_d = RR_RESP;
        end else if (req_s) begin
          state_d = RR_BUSY;
          cnt_d   = LAT_M1;
        end else begin
          state_d = RR_IDLE;
        end
      end
      RR_BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = RR_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RR_RESP: state_d = RR_IDLE;
      default: state_d = RR_IDLE;
    endcase
  end

  // Request latch plus sticky error and read-data select, updated on the committing edge.
  always_comb begin
    if (idle_s && req_s) begin
      op_d    = cur_op_s;
      addr_d  = cur_addr_s;
      wdata_d = cur_wdata_s;
      both_d  = cur_both_s;
    end else begin
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      both_d  = both_q;
    end
    if (access_s) begin
      err_d = err_q | oor_s | cur_both_s;
      if (cur_op_s != RR_OP_WR) begin
        rsel_d = ~oor_s;
      end else begin
        rsel_d = rsel_q;
      end
    end else begin
      err_d  = err_q;
      rsel_d = rsel_q;
    end
  end

  // Handshake outputs follow the next state so they are registered alongside it.
  always_comb begin
    wait_d = (state_d == RR_BUSY);
    ack_d  = (state_d == RR_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RR_IDLE;
      op_q    <= RR_OP_RD;
      cnt_q   <= 8'd0;
      addr_q  <= {DATA_ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      both_q  <= 1'b0;
      err_q   <= 1'b0;
      rsel_q  <= 1'b0;
      wait_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      both_q  <= both_d;
      err_q   <= err_d;
      rsel_q  <= rsel_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
    end
  end

  ram_responder_array #(
    .WORDS (MEM_WORDS),
    .AW    (IDX_W),
    .DW    (DATA_W)
  ) u_array (
    .clk     (clk),
    .en_i    (access_s & ~oor_s),
    .we_i    (cur_op_s != RR_OP_RD),
    .re_i    (cur_op_s != RR_OP_WR),
    .addr_i  (cur_addr_s[IDX_W-1:0]),
    .wdata_i (cur_wdata_s),
    .rdata_o (arr_rdata_s)
  );

  // Array output only changes on read/swap commits; rsel_q forces zero after reset or out-of-range reads.
  assign ram_data_r = rsel_q ? arr_rdata_s : {DATA_W{1'b0}};
  assign ram_wait   = wait_q;
  assign ram_ack    = ack_q;
  assign ram_err    = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench: two responders (3 and 0 wait states) against a word-array reference model.
module tb_ram_responder;

  localparam int LAT0 = 3;
  localparam int LAT1 = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       rd, wr, at, wt, ak, er;
  logic [1:0][31:0] addr, wdat, rdat;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  exp_t        mon_e;
  logic [31:0] mdl [2][4096];
  logic [31:0] last_m [2];
  logic        err_m [2];
  int          ack_seen [2];
  int          run [2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_responder #(.LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ram_addr(addr[0]), .ram_data_w(wdat[0]),
    .ram_read(rd[0]), .ram_write(wr[0]), .ram_atomic(at[0]),
    .ram_wait(wt[0]), .ram_ack(ak[0]), .ram_data_r(rdat[0]), .ram_err(er[0])
  );

  ram_responder #(.LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ram_addr(addr[1]), .ram_data_w(wdat[1]),
    .ram_read(rd[1]), .ram_write(wr[1]), .ram_atomic(at[1]),
    .ram_wait(wt[1]), .ram_ack(ak[1]), .ram_data_r(rdat[1]), .ram_err(er[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ack(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ak[i] && n < 300);
    if (!ak[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout inst%0d: got no ack expected ack within 300 cycles", i);
    end
    ack_seen[i] = cyc;
  endtask

  // Drive one request (held until its ack), predict the response from the model, queue it.
  task automatic issue(input int i, input logic r, input logic w, input logic a,
                       input logic [31:0] ad, input logic [31:0] wd);
    exp_t e;
    int   acc;
    logic oor;
    int   ix;
    acc = (ack_seen[i] == cyc) ? cyc + 2 : cyc + 1;
    rd[i] = r; wr[i] = w; at[i] = a; addr[i] = ad; wdat[i] = wd;
    oor = (ad[31:12] != 20'd0);
    ix  = int'(ad[11:0]);
    if (!w || a) last_m[i] = oor ? 32'd0 : mdl[i][ix];
    if (w && !oor) mdl[i][ix] = wd;
    if (oor || (r && w && !a)) err_m[i] = 1'b1;
    e.data = last_m[i];
    e.err  = err_m[i];
    e.cyc  = acc + ((i == 0) ? LAT0 : LAT1);
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    wait_ack(i);
  endtask

  task automatic idle(input int i);
    rd[i] = 1'b0; wr[i] = 1'b0; at[i] = 1'b0;
  endtask

  // Monitor: every ack pops one prediction; wait must have been high exactly LATENCY cycles before it.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ak[i]) begin
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack inst%0d: got ack expected none at cycle %0d", i, cyc);
        end else begin
          if (i == 0) mon_e = exp_q0.pop_front();
          else        mon_e = exp_q1.pop_front();
          chk($sformatf("data_r inst%0d", i), rdat[i], mon_e.data);
          chk($sformatf("err inst%0d", i), 32'(er[i]), 32'(mon_e.err));
          chk($sformatf("ack_cycle inst%0d", i), 32'(cyc), 32'(mon_e.cyc));
          chk($sformatf("wait_len inst%0d", i), 32'(run[i]), 32'((i == 0) ? LAT0 : LAT1));
        end
        run[i] = 0;
      end else if (wt[i]) begin
        run[i] = run[i] + 1;
      end else begin
        run[i] = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [31:0] ad;
    rst_n = 1'b0;
    rd = 2'b00; wr = 2'b00; at = 2'b00; addr = '0; wdat = '0;
    for (int i = 0; i < 2; i++) begin
      ack_seen[i] = -10; run[i] = 0; last_m[i] = 32'd0; err_m[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset wait inst%0d", i), 32'(wt[i]), 32'd0);
      chk($sformatf("reset ack inst%0d", i), 32'(ak[i]), 32'd0);
      chk($sformatf("reset data inst%0d", i), rdat[i], 32'd0);
      chk($sformatf("reset err inst%0d", i), 32'(er[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the low 64 words of both memories so every later read has a known answer.
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 64; a++) issue(i, 1'b0, 1'b1, 1'b0, 32'(a), $urandom);
      idle(i);
    end
    issue(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h55);
    issue(0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h11);
    idle(0);
    repeat (2) @(negedge clk);

    // Directed scenarios on the 3-wait-state instance.
    issue(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    chk("read_deadbeef", rdat[0], 32'hDEADBEEF);
    issue(0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h1);
    chk("swap_old", rdat[0], 32'h55);
    issue(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    chk("swap_new", rdat[0], 32'h1);
    chk("err_clean", 32'(er[0]), 32'd0);
    issue(0, 1'b0, 1'b1, 1'b0, 32'h0001_0005, 32'hCAFEF00D);
    issue(0, 1'b1, 1'b0, 1'b0, 32'h5, 32'h0);
    issue(0, 1'b1, 1'b0, 1'b0, 32'h0001_0005, 32'h0);
    chk("oor_read_zero", rdat[0], 32'h0);
    chk("oor_err", 32'(er[0]), 32'd1);
    issue(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'hA5);
    issue(0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    chk("rw_both_write", rdat[0], 32'hA5);
    chk("err_sticky", 32'(er[0]), 32'd1);
    idle(0);
    repeat (2) @(negedge clk);

    // Reset during the second wait cycle of a write: the write must never reach memory.
    wr[0] = 1'b1; addr[0] = 32'h40; wdat[0] = 32'h77;
    @(negedge clk);
    idle(0);
    @(negedge clk);
    chk("busy_before_reset", 32'(wt[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset wait", 32'(wt[0]), 32'd0);
    chk("midreset ack", 32'(ak[0]), 32'd0);
    chk("midreset err", 32'(er[0]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      err_m[i] = 1'b0; last_m[i] = 32'd0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    chk("dropped_write", rdat[0], 32'h11);
    idle(0);

    // Zero-wait instance: 16 reads with the request held continuously.
    for (int a = 0; a < 16; a++) issue(1, 1'b1, 1'b0, 1'b0, 32'(a), 32'h0);
    idle(1);
    repeat (2) @(negedge clk);

    // Random back-to-back mix on both instances.
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 40; n++) begin
        k = $urandom_range(0, 4);
        if ($urandom_range(0, 7) == 0)
          ad = {20'($urandom_range(1, 1048575)), 12'($urandom_range(0, 63))};
        else
          ad = 32'($urandom_range(0, 63));
        case (k)
          0:       issue(i, 1'b1, 1'b0, 1'b0, ad, $urandom);
          1:       issue(i, 1'b0, 1'b1, 1'b0, ad, $urandom);
          2:       issue(i, 1'b0, 1'b1, 1'b1, ad, $urandom);
          3:       issue(i, 1'b1, 1'b1, 1'b0, ad, $urandom);
          default: issue(i, 1'b1, 1'b0, 1'b1, ad, $urandom);
        endcase
      end
      idle(i);
    end

    repeat (10) @(negedge clk);
    chk("pending inst0", 32'(exp_q0.size()), 32'd0);
    chk("pending inst1", 32'(exp_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
